// File: rtl/escalonador_escrita_regs_pkg.sv
// -----------------------------------------------------------------------------
// escalonador_escrita_regs_pkg
// Shared definitions for the register-file write scheduler:
//   - FSM state encoding of the write sequence (IDLE/SETUP/STROBE/HOLD)
//   - REG_ZERO, the hard-wired zero register index
//   - default address/data widths
//   - can_accept(): states in which a new writeback may be accepted
// -----------------------------------------------------------------------------
package escalonador_escrita_regs_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    localparam logic [4:0] REG_ZERO = 5'h0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } esc_state_t;

    // The write port is free in IDLE and in the last cycle of a sequence.
    function automatic logic can_accept(input esc_state_t s);
        return (s == ST_IDLE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/escalonador_escrita_regs_arbitro_rr2.sv
// -----------------------------------------------------------------------------
// arbitro_rr2
// Two-way round-robin arbiter. req[0] is the ALU, req[1] the load unit.
// A single requester always wins; with both requesting, the one that was not
// granted last wins. The pointer moves whenever advance is high (a grant was
// taken). After reset the pointer favours req[0].
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   req[1:0]      request vector
//   advance       a grant was consumed this cycle
//   grant[1:0]    one-hot (or zero) grant, combinational
// -----------------------------------------------------------------------------
module arbitro_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 when req[1] was granted most recently.
    logic last_mem;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_mem ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_mem <= 1'b1;
        end else if (advance) begin
            last_mem <= grant[1];
        end
    end

endmodule

// File: rtl/escalonador_escrita_regs.sv
// -----------------------------------------------------------------------------
// escalonador_escrita_regs
// Write-port scheduler for the 32x32 register file. Arbitrates between the ALU
// and load-unit writeback requesters (round robin), turns each accepted write
// into a setup / strobe / hold sequence on the file's edge-sensitive wr input,
// and keeps a per-register busy scoreboard for RAW hazard detection.
//
// Optional feature (macro ESC_FWD_EN): forwarding of the in-flight write to
// decode; while the write is in STROBE or HOLD a matching source sees
// fwd*_valid=1 and its hazard is suppressed. Without the macro the fwd outputs
// are tied to 0.
//
// Ports:
//   clk, rst                        clock / asynchronous active-high reset
//   alu_valid/rd/data, alu_ready    ALU writeback request
//   mem_valid/rd/data, mem_ready    load writeback request
//   issue_valid, issue_rd           destination of an issued instruction
//   rs1, rs2, hazard1, hazard2      decode sources and their hazard flags
//   rf_rd, rf_wr_data, rf_wr        register file write port
//   fwd1_valid, fwd2_valid, fwd_data  forwarding (ESC_FWD_EN)
// -----------------------------------------------------------------------------
module escalonador_escrita_regs
    import escalonador_escrita_regs_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              rf_wr,
    output logic              fwd1_valid,
    output logic              fwd2_valid,
    output logic [DATA_W-1:0] fwd_data
);

    esc_state_t          state;
    logic [NUM_REGS-1:0] busy;
    logic [1:0]          grant;
    logic                hs_any;
    logic                start_seq;
    logic [ADDR_W-1:0]   hs_rd;
    logic [DATA_W-1:0]   hs_data;
    logic                raw1;
    logic                raw2;

    // Handshake: a transfer happens in any cycle where a requester's valid and
    // its ready are both high; rd/data are captured at that rising edge.
    // ready is combinational, only offered in IDLE/HOLD, and only to the
    // requester the arbiter grants, so at most one ready is high. Requesters
    // keep valid/rd/data stable until they see ready.
    arbitro_rr2 u_arbitro (
        .clk     (clk),
        .rst     (rst),
        .req     ({mem_valid, alu_valid}),
        .advance (hs_any),
        .grant   (grant)
    );

    assign alu_ready = can_accept(state) & grant[0];
    assign mem_ready = can_accept(state) & grant[1];
    assign hs_any    = alu_ready | mem_ready;
    assign hs_rd     = mem_ready ? mem_rd   : alu_rd;
    assign hs_data   = mem_ready ? mem_data : alu_data;

    // Writes to x0 are acknowledged but never reach the register file.
    assign start_seq = hs_any && (hs_rd != '0);

    // rf_wr is a register so the file's wr input sees a glitch-free pulse
    // with address/data already stable one cycle before and after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rf_wr      <= 1'b0;
            rf_rd      <= '0;
            rf_wr_data <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (start_seq) begin
                        state      <= ST_SETUP;
                        rf_rd      <= hs_rd;
                        rf_wr_data <= hs_data;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                    rf_wr <= 1'b1;
                end
                ST_STROBE: begin
                    state <= ST_HOLD;
                    rf_wr <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    rf_wr <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard. The set is written after the clear so that a new producer
    // issued in the cycle the previous write retires keeps the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (state == ST_HOLD) begin
                busy[rf_rd] <= 1'b0;
            end
            if (issue_valid && (issue_rd != '0)) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

    assign raw1 = (rs1 != '0) & busy[rs1];
    assign raw2 = (rs2 != '0) & busy[rs2];

`ifdef ESC_FWD_EN
    logic fwd_window;

    // The file has taken the data from STROBE onwards, so from then until the
    // sequence retires the latched value can be handed straight to decode.
    assign fwd_window = (state == ST_STROBE) || (state == ST_HOLD);
    assign fwd1_valid = fwd_window && (rf_rd != '0) && (rs1 == rf_rd);
    assign fwd2_valid = fwd_window && (rf_rd != '0) && (rs2 == rf_rd);
    assign fwd_data   = rf_wr_data;
    assign hazard1    = raw1 & ~fwd1_valid;
    assign hazard2    = raw2 & ~fwd2_valid;
`else
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd_data   = '0;
    assign hazard1    = raw1;
    assign hazard2    = raw2;
`endif

endmodule

// File: tb/tb_escalonador_escrita_regs.sv
module tb_escalonador_escrita_regs;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              alu_valid, mem_valid, issue_valid;
  logic [ADDR_W-1:0] alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready, hazard1, hazard2, rf_wr;
  logic              fwd1_valid, fwd2_valid;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wr_data, fwd_data;

  escalonador_escrita_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .hazard1(hazard1), .hazard2(hazard2),
    .rf_rd(rf_rd), .rf_wr_data(rf_wr_data), .rf_wr(rf_wr),
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid), .fwd_data(fwd_data)
  );

  // ---------------- register file fed by the DUT ----------------
  logic [DATA_W-1:0] dut_x[32];
  always @(posedge rf_wr) dut_x[rf_rd] <= rf_wr_data;

  // ---------------- behavioural model ----------------
  int                checks = 0;
  int                passed = 0;
  int                cyc = 0;
  int                hs_cyc;      // cycle whose closing edge accepted the last real write
  bit                last_mem;    // load unit was granted most recently
  logic [ADDR_W-1:0] lat_rd;
  logic [DATA_W-1:0] lat_data;
  bit                busy_m[32];
  logic [DATA_W-1:0] ref_x[32];
  bit                exp_alu, exp_mem;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    hs_cyc   = -100;
    last_mem = 1'b1;
    lat_rd   = '0;
    lat_data = '0;
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
  endtask

  // Compare every DUT output against the model for the current cycle.
  // A write accepted at the end of cycle h occupies h+1 (setup), h+2 (strobe)
  // and h+3 (hold); the port can take a new request in any other cycle.
  task automatic check_cycle();
    int d;
    bit free, f1, f2;
    d    = cyc - hs_cyc;
    free = (d != 1) && (d != 2);
    exp_alu = free && alu_valid && (!mem_valid || last_mem);
    exp_mem = free && mem_valid && (!alu_valid || !last_mem);
`ifdef ESC_FWD_EN
    f1 = (d == 2 || d == 3) && (rs1 != 0) && (rs1 == lat_rd);
    f2 = (d == 2 || d == 3) && (rs2 != 0) && (rs2 == lat_rd);
    chk("fwd_data", fwd_data, lat_data);
`else
    f1 = 1'b0;
    f2 = 1'b0;
    chk("fwd_data", fwd_data, '0);
`endif
    chk1("alu_ready", alu_ready, exp_alu);
    chk1("mem_ready", mem_ready, exp_mem);
    chk1("rf_wr", rf_wr, d == 2);
    chk("rf_rd", {27'd0, rf_rd}, {27'd0, lat_rd});
    chk("rf_wr_data", rf_wr_data, lat_data);
    chk1("fwd1_valid", fwd1_valid, f1);
    chk1("fwd2_valid", fwd2_valid, f2);
    chk1("hazard1", hazard1, (rs1 != 0) && busy_m[rs1] && !f1);
    chk1("hazard2", hazard2, (rs2 != 0) && busy_m[rs2] && !f2);
    if (d == 2) ref_x[lat_rd] = lat_data;
  endtask

  // Apply the model's view of the closing edge, then move to the next cycle.
  task automatic advance();
    int d;
    bit any;
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] dat;
    d   = cyc - hs_cyc;
    any = 1'b0;
    r   = '0;
    dat = '0;
    if (d == 3) busy_m[lat_rd] = 1'b0;
    if (exp_alu) begin r = alu_rd; dat = alu_data; last_mem = 1'b0; any = 1'b1; end
    else if (exp_mem) begin r = mem_rd; dat = mem_data; last_mem = 1'b1; any = 1'b1; end
    if (any && r != 0) begin
      assert (!(d == 3 && r == lat_rd)) else $error("two producers to x%0d overlap", r);
      hs_cyc   = cyc;
      lat_rd   = r;
      lat_data = dat;
    end
    if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_alu) alu_valid = 1'b0;
    if (exp_mem) mem_valid = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    check_cycle();
    advance();
  endtask

  task automatic step();
    sample();
    finish_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    issue_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc++;
  endtask

  // Random destination that never collides with a write still in flight or
  // with the other requester's pending destination.
  function automatic logic [ADDR_W-1:0] pick_rd(input bit other_v, input logic [ADDR_W-1:0] other);
    logic [ADDR_W-1:0] r;
    int d;
    d = cyc - hs_cyc;
    if ($urandom_range(0, 7) == 0) return '0;
    r = ADDR_W'($urandom_range(1, 31));
    while ((d >= 1 && d <= 3 && r == lat_rd) || (other_v && r == other))
      r = ADDR_W'($urandom_range(1, 31));
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    for (int i = 0; i < 32; i++) begin dut_x[i] = '0; ref_x[i] = '0; end
    model_reset();
    do_reset();

    // Reset state
    rs1 = 5; rs2 = 5;
    sample();
    chk1("reset_rf_wr", rf_wr, 1'b0);
    chk("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("reset_rf_wr_data", rf_wr_data, 32'd0);
    chk1("reset_hazard1", hazard1, 1'b0);
    finish_cycle();

    // ALU-only write x5
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    sample(); chk1("t1_accept", alu_ready, 1'b1); finish_cycle();
    sample(); chk1("t1_setup_wr", rf_wr, 1'b0); chk("t1_setup_rd", {27'd0, rf_rd}, 32'd5);
    chk("t1_setup_data", rf_wr_data, 32'hDEADBEEF); finish_cycle();
    sample(); chk1("t1_strobe_wr", rf_wr, 1'b1); chk("t1_strobe_rd", {27'd0, rf_rd}, 32'd5); finish_cycle();
    sample(); chk1("t1_hold_wr", rf_wr, 1'b0); chk("t1_hold_data", rf_wr_data, 32'hDEADBEEF); finish_cycle();
    step();
    chk("t1_x5", dut_x[5], 32'hDEADBEEF);

    // Contention from reset: ALU first, load accepted in HOLD, strobes 3 apart
    do_reset();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33333333;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h44444444;
    sample(); chk1("t2_alu_first", alu_ready, 1'b1); chk1("t2_mem_wait", mem_ready, 1'b0); finish_cycle();
    sample(); chk1("t2_mem_wait_setup", mem_ready, 1'b0); finish_cycle();
    sample(); chk1("t2_strobe_a", rf_wr, 1'b1); chk("t2_rd_a", {27'd0, rf_rd}, 32'd3); finish_cycle();
    sample(); chk1("t2_mem_in_hold", mem_ready, 1'b1); finish_cycle();
    sample(); chk1("t2_setup_b", rf_wr, 1'b0); finish_cycle();
    sample(); chk1("t2_strobe_b", rf_wr, 1'b1); chk("t2_rd_b", {27'd0, rf_rd}, 32'd4); finish_cycle();
    step(); step();
    chk("t2_x3", dut_x[3], 32'h33333333);
    chk("t2_x4", dut_x[4], 32'h44444444);

    // rd = 0 is acknowledged but never written
    mem_valid = 1; mem_rd = 0; mem_data = 32'h1234;
    sample(); chk1("t3_ready", mem_ready, 1'b1); finish_cycle();
    for (int k = 0; k < 4; k++) begin
      sample(); chk1("t3_no_wr", rf_wr, 1'b0); chk("t3_rd_kept", {27'd0, rf_rd}, 32'd4); finish_cycle();
    end
    chk("t3_x0", dut_x[0], 32'd0);

    // Scoreboard on x7
    rs1 = 7; issue_valid = 1; issue_rd = 7;
    sample(); chk1("t4_not_yet", hazard1, 1'b0); finish_cycle();
    issue_valid = 0;
    sample(); chk1("t4_busy", hazard1, 1'b1); finish_cycle();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    step(); step(); step();
    sample(); chk1("t4_busy_in_hold", hazard1, 1'b1); finish_cycle();
    sample(); chk1("t4_cleared", hazard1, 1'b0); finish_cycle();
    issue_valid = 1; issue_rd = 7;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
    step(); step(); step();
    issue_valid = 1; issue_rd = 7;
    step();
    issue_valid = 0;
    sample(); chk1("t4_set_wins", hazard1, 1'b1); finish_cycle();

    // Asynchronous reset during STROBE
    rs1 = 6; issue_valid = 1; issue_rd = 6;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    step(); step();
    sample(); check_cycle(); chk1("t5_strobe", rf_wr, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("t5_async_wr", rf_wr, 1'b0);
    chk1("t5_async_hazard", hazard1, 1'b0);
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA0A0;
    mem_valid = 1; mem_rd = 11; mem_data = 32'hB1B1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc++;
    sample(); chk1("t5_alu_after_rst", alu_ready, 1'b1); chk1("t5_mem_after_rst", mem_ready, 1'b0); finish_cycle();
    for (int k = 0; k < 7; k++) step();

    // Forwarding window on x9
    rs2 = 9; issue_valid = 1; issue_rd = 9;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'hA5A5A5A5;
    step(); step();
    sample();
`ifdef ESC_FWD_EN
    chk1("t6_fwd2", fwd2_valid, 1'b1);
    chk("t6_fwd_data", fwd_data, 32'hA5A5A5A5);
    chk1("t6_hazard2", hazard2, 1'b0);
`else
    chk1("t6_fwd2_off", fwd2_valid, 1'b0);
    chk1("t6_hazard2", hazard2, 1'b1);
`endif
    finish_cycle();
    step(); step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!alu_valid && $urandom_range(0, 99) < 50) begin
        alu_rd = pick_rd(mem_valid, mem_rd);
        alu_data = $urandom;
        alu_valid = 1;
      end
      if (!mem_valid && $urandom_range(0, 99) < 50) begin
        mem_rd = pick_rd(alu_valid, alu_rd);
        mem_data = $urandom;
        mem_valid = 1;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd = ADDR_W'($urandom_range(0, 31));
      rs1 = ADDR_W'($urandom_range(0, 15));
      rs2 = ADDR_W'($urandom_range(0, 15));
      step();
    end
    issue_valid = 0;
    for (int k = 0; k < 20; k++) step();

    for (int i = 0; i < 32; i++) chk($sformatf("final_x%0d", i), dut_x[i], ref_x[i]);
    chk("final_x0_zero", dut_x[0], 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
